// File: rtl/mux4_sel_reg_pkg.sv
// Shared select-code constants and status types for the 4:1 steering mux.
// Imported by the interface, the combinational mux and the registered top.
package mux4_sel_reg_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

    // Registered status that is always clocked, whatever the output mode of z.
    typedef struct packed {
        logic valid;
        sel_t sel;
        logic changed;
    } status_t;

    localparam status_t STATUS_RESET = '{valid: 1'b0, sel: SEL_A, changed: 1'b0};

    // x is the select MSB, y the LSB.
    function automatic sel_t sel_code(input logic x, input logic y);
        return {x, y};
    endfunction

endpackage

// File: rtl/mux4_sel_reg_if.sv
// Bundle of select, data, enable and status lines of the 4:1 steering mux.
// master drives the selects and data; slave is the mux itself.
interface mux4_sel_reg_if #(
    parameter int WIDTH = 1
);
    import mux4_sel_reg_pkg::*;

    logic             x;
    logic             y;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             en;
    logic [WIDTH-1:0] z;
    logic             z_valid;
    sel_t             sel_q;
    logic             z_changed;

    modport master (
        output x, y, a, b, c, d, en,
        input  z, z_valid, sel_q, z_changed
    );

    modport slave (
        input  x, y, a, b, c, d, en,
        output z, z_valid, sel_q, z_changed
    );

endinterface

// File: rtl/mux4_sel_reg_mux4_comb.sv
// Purely combinational 4:1 selector; the select map is complete, so there
// is no fallback branch.
module mux4_comb
    import mux4_sel_reg_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  sel_t             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_comb begin
                case (sel)
                    SEL_A: y[gi] = a[gi];
                    SEL_B: y[gi] = b[gi];
                    SEL_C: y[gi] = c[gi];
                    SEL_D: y[gi] = d[gi];
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/mux4_sel_reg.sv
// 4:1 steering mux with registered (or pass-through) output, select echo,
// valid flag and a one-cycle change pulse on captured z.
module mux4_sel_reg
    import mux4_sel_reg_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter bit REGISTER_OUT = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    mux4_sel_reg_if.slave bus
);

    sel_t             sel;
    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] z_reg;
    logic [WIDTH-1:0] z_next;
    status_t          status_reg;
    status_t          status_next;

    assign sel = sel_code(bus.x, bus.y);

    mux4_comb #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (sel),
        .a   (bus.a),
        .b   (bus.b),
        .c   (bus.c),
        .d   (bus.d),
        .y   (mux_y)
    );

    // The change detector compares against z_reg even in pass-through mode,
    // so z_changed means the same thing for both output modes.
    always_comb begin
        z_next      = z_reg;
        status_next = status_reg;
        if (bus.en) begin
            z_next             = mux_y;
            status_next.sel    = sel;
            status_next.valid  = 1'b1;
            status_next.changed = (mux_y != z_reg) && status_reg.valid;
        end else begin
            status_next.changed = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_reg      <= '0;
            status_reg <= STATUS_RESET;
        end else begin
            z_reg      <= z_next;
            status_reg <= status_next;
        end
    end

    generate
        if (REGISTER_OUT) begin : g_z_reg
            assign bus.z = z_reg;
        end else begin : g_z_comb
            assign bus.z = mux_y;
        end
    endgenerate

    assign bus.z_valid   = status_reg.valid;
    assign bus.sel_q     = status_reg.sel;
    assign bus.z_changed = status_reg.changed;

`ifndef SYNTHESIS
    // An unknown select while capturing would load garbage silently.
    a_sel_known: assert property (@(posedge clk) disable iff (!rst_n)
        bus.en |-> !$isunknown({bus.x, bus.y}))
        else $error("mux4_sel_reg: unknown select while en=1");
`endif

endmodule

// File: tb/tb_mux4_sel_reg.sv
// Bench for mux4_sel_reg: 8-bit registered, 8-bit pass-through and 1-bit
// registered instances, checked against constant tables via a scoreboard.
module tb_mux4_sel_reg;
    import mux4_sel_reg_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stimulus shared by the 8-bit instances.
    logic       x = 1'b0, y = 1'b0, en = 1'b0;
    logic [7:0] a = '0, b = '0, c = '0, d = '0;
    // Stimulus for the 1-bit instance.
    logic       x1 = 1'b0, y1 = 1'b0, en1 = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, d1 = 1'b0;

    mux4_sel_reg_if #(.WIDTH(8)) if8 ();
    mux4_sel_reg_if #(.WIDTH(8)) if0 ();
    mux4_sel_reg_if #(.WIDTH(1)) if1 ();

    assign if8.x = x;  assign if8.y = y;  assign if8.en = en;
    assign if8.a = a;  assign if8.b = b;  assign if8.c = c;  assign if8.d = d;
    assign if0.x = x;  assign if0.y = y;  assign if0.en = en;
    assign if0.a = a;  assign if0.b = b;  assign if0.c = c;  assign if0.d = d;
    assign if1.x = x1; assign if1.y = y1; assign if1.en = en1;
    assign if1.a = a1; assign if1.b = b1; assign if1.c = c1; assign if1.d = d1;

    mux4_sel_reg #(.WIDTH(8), .REGISTER_OUT(1'b1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    mux4_sel_reg #(.WIDTH(8), .REGISTER_OUT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mux4_sel_reg #(.WIDTH(1), .REGISTER_OUT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [7:0] z;
        logic       v;
        logic [1:0] sel;
        logic       ch;
    } exp_t;

    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic [7:0] a, b, c, d;
        logic [7:0] ez;
        logic       ev;
        logic [1:0] esel;
        logic       ech;
    } vec_t;

    exp_t sb8[$];
    exp_t sb1[$];
    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] mux_ref(input logic [1:0] s, input logic [7:0] ia,
                                           input logic [7:0] ib, input logic [7:0] ic,
                                           input logic [7:0] id);
        case (s)
            2'b00:   return ia;
            2'b01:   return ib;
            2'b10:   return ic;
            default: return id;
        endcase
    endfunction

    initial begin
        exp_t       e;
        logic [1:0] s1_seq [4];
        logic       z1_seq [4];
        logic       ch1_seq[4];

        // sel, en, a, b, c, d -> z, valid, sel_q, z_changed
        vt[0]  = '{2'b00, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 1'b1, 2'b00, 1'b0};
        vt[1]  = '{2'b01, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22, 1'b1, 2'b01, 1'b1};
        vt[2]  = '{2'b10, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h33, 1'b1, 2'b10, 1'b1};
        vt[3]  = '{2'b11, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 1'b1, 2'b11, 1'b1};
        vt[4]  = '{2'b01, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22, 1'b1, 2'b01, 1'b1};
        vt[5]  = '{2'b11, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22, 1'b1, 2'b01, 1'b0};
        vt[6]  = '{2'b11, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 1'b1, 2'b11, 1'b1};
        vt[7]  = '{2'b11, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 1'b1, 2'b11, 1'b0};
        vt[8]  = '{2'b00, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 1'b1, 2'b00, 1'b1};
        vt[9]  = '{2'b01, 1'b1, 8'h11, 8'h55, 8'h33, 8'h44, 8'h55, 1'b1, 2'b01, 1'b1};
        vt[10] = '{2'b01, 1'b1, 8'h11, 8'h55, 8'h33, 8'h44, 8'h55, 1'b1, 2'b01, 1'b0};

        s1_seq  = '{2'b00, 2'b10, 2'b11, 2'b01};
        z1_seq  = '{1'b0, 1'b0, 1'b1, 1'b1};
        ch1_seq = '{1'b0, 1'b0, 1'b1, 1'b0};

        // Reset held across clock edges with live inputs.
        rst_n = 1'b0;
        {x, y} = 2'b10; en = 1'b1;
        a = 8'h5A; b = 8'hC3; c = 8'h7E; d = 8'h81;
        {x1, y1} = 2'b11; en1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; d1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst8_z", if8.z, 8'h00);
        chk("rst8_valid", if8.z_valid, 1'b0);
        chk("rst8_sel_q", if8.sel_q, 2'b00);
        chk("rst8_changed", if8.z_changed, 1'b0);
        chk("rst1_z", if1.z, 1'b0);
        chk("rst0_z_comb", if0.z, 8'h7E);
        chk("rst0_valid", if0.z_valid, 1'b0);
        chk("rst0_sel_q", if0.sel_q, 2'b00);
        rst_n = 1'b1;

        // 1-bit truth table: z follows the y select bit.
        {x1, y1} = 2'b00; a1 = 1'b0; b1 = 1'b1; c1 = 1'b0; d1 = 1'b1; en1 = 1'b1;
        {x, y} = 2'b11; d = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            {x1, y1} = s1_seq[i];
            sb1.push_back('{{7'd0, z1_seq[i]}, 1'b1, s1_seq[i], ch1_seq[i]});
            @(posedge clk);
            #1;
            e = sb1.pop_front();
            chk($sformatf("tt1_z[%0d]", i), if1.z, e.z[0]);
            chk($sformatf("tt1_sel_q[%0d]", i), if1.sel_q, e.sel);
            chk($sformatf("tt1_changed[%0d]", i), if1.z_changed, e.ch);
            chk($sformatf("tt1_valid[%0d]", i), if1.z_valid, e.v);
        end

        // Asynchronous reset between edges clears everything without a clock.
        chk("pre_async_z8", if8.z, 8'hA5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async8_z", if8.z, 8'h00);
        chk("async8_valid", if8.z_valid, 1'b0);
        chk("async8_sel_q", if8.sel_q, 2'b00);
        chk("async1_z", if1.z, 1'b0);
        chk("async1_valid", if1.z_valid, 1'b0);
        chk("async1_sel_q", if1.sel_q, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table: sweep, enable hold, simultaneous select/data change.
        for (int i = 0; i < 11; i++) begin
            {x, y} = vt[i].sel; en = vt[i].en;
            a = vt[i].a; b = vt[i].b; c = vt[i].c; d = vt[i].d;
            sb8.push_back('{vt[i].ez, vt[i].ev, vt[i].esel, vt[i].ech});
            #1;
            chk($sformatf("vec%0d_comb_z", i), if0.z, mux_ref(vt[i].sel, vt[i].a, vt[i].b, vt[i].c, vt[i].d));
            @(posedge clk);
            #1;
            e = sb8.pop_front();
            chk($sformatf("vec%0d_z", i), if8.z, e.z);
            chk($sformatf("vec%0d_valid", i), if8.z_valid, e.v);
            chk($sformatf("vec%0d_sel_q", i), if8.sel_q, e.sel);
            chk($sformatf("vec%0d_changed", i), if8.z_changed, e.ch);
            chk($sformatf("vec%0d_p_sel_q", i), if0.sel_q, e.sel);
            chk($sformatf("vec%0d_p_changed", i), if0.z_changed, e.ch);
        end

        chk("sb_drained", sb8.size() + sb1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux4_sel_reg.md
Name: mux4_sel_reg

Overview:
- 4:1 selector: two select bits (x, y) choose one of four data inputs (a, b, c, d) and drive it onto output z.
- Output is registered; the block also reports the registered select code and flags when the output value changes.
- Sits in the TDC datapath wherever one of four tap or reference signals must be steered onto a single line under 2-bit control.

Parameters:
- WIDTH, 1, bit width of a, b, c, d and z.
- REGISTER_OUT, 1, 1 = z registered (1-cycle latency); 0 = z combinational from current inputs, while status outputs stay registered.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x  in  1  select MSB.
- y  in  1  select LSB.
- a  in  WIDTH  data input, selected when {x,y}=00.
- b  in  WIDTH  data input, selected when {x,y}=01.
- c  in  WIDTH  data input, selected when {x,y}=10.
- d  in  WIDTH  data input, selected when {x,y}=11.
- en  in  1  capture enable; registers hold their value when low.
- z  out  WIDTH  selected data.
- z_valid  out  1  high once at least one enabled capture has occurred since reset.
- sel_q  out  2  registered select code {x,y} of the last capture.
- z_changed  out  1  one-cycle pulse: the last capture produced a z different from the previous captured z.

Behaviour:
- Select decode: sel = {x,y}. 00 selects a, 01 selects b, 10 selects c, 11 selects d. Full case; there is no default other than this map.
- Reset (rst_n low, asynchronous assert): z=0, z_valid=0, sel_q=00, z_changed=0 immediately, regardless of clk. Deassertion takes effect at the next rising clk edge. The design requires rst_n deassertion to be synchronous to clk externally.
- REGISTER_OUT=1, on each rising clk edge with en=1:
  - z <= mux(sel).
  - sel_q <= sel.
  - z_valid <= 1.
  - z_changed <= (mux(sel) != z) AND z_valid. The first capture after reset never flags a change.
- en=0: z, sel_q and z_valid hold; z_changed <= 0.
- REGISTER_OUT=0: z = mux(sel) combinationally, and is not gated by en or reset. sel_q, z_valid and z_changed behave exactly as above, using the internally registered copy of z for the comparison.
- Latency: 1 clk from x, y, a–d to z when REGISTER_OUT=1; 0 when REGISTER_OUT=0.
- Simultaneous select and data change in one cycle: the captured value is the mux of the values present at the clock edge. There is no priority issue.
- Reset asserted mid-operation: all state clears at once; the next capture after release has z_changed=0.
- Unknown or X select: not permitted. The simulation assertion flags X on x or y while en=1 and rst_n=1.
- All arithmetic is bitwise equality compare over WIDTH bits. There is no sign handling.

Decomposition:
- Shared package: select-code constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
- One natural combinational sub-module, mux4_comb: inputs sel, a, b, c, d; output y. The top instantiates it and adds the output register, valid bit, change detector and X assertion.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs and toggle clk -> z=0, z_valid=0, sel_q=00, z_changed=0. Then assert rst_n low between clk edges and check that the outputs clear without a clock edge.
- Truth table, WIDTH=1, a=0, b=1, c=0, d=1, en=1. Sequence {x,y}=00, 10, 11, 01, one select per cycle -> z=0, 0, 1, 1 after one cycle each, so z equals y. z_changed pulses only on the 10->11 capture. sel_q tracks 00, 10, 11, 01.
- Distinct data, WIDTH=8, a=8'h11, b=8'h22, c=8'h33, d=8'h44. Sweep sel 00..11 -> z=11, 22, 33, 44, each with 1-cycle latency and a z_changed pulse on every step after the first.
- Enable hold: capture z=8'h22, then drive en=0 and change sel to 11 -> z stays 22, sel_q stays 01, z_changed=0. Raise en -> z=44 next cycle and z_changed=1.
- Simultaneous change: in one cycle change sel 00->01 and change b from 22 to 55 -> z=55 after the edge.
- REGISTER_OUT=0: sweep sel -> z follows combinationally within the same cycle, including while rst_n=0. sel_q and z_changed are still one cycle late and reset-cleared.
